// File: rtl/cp0_ex_ctrl.sv
// Exception/ERET commit controller at WB: picks the committing instruction's exception,
// pulses CP0, flushes the pipeline and holds commits until fetch accepts the redirect.
module cp0_ex_ctrl #(
   parameter logic [31:0] EX_VECTOR = 32'hBFC00380,
   parameter int          INT_SYNC  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   output logic        wb_allowin,
   input  logic [31:0] wb_pc,
   input  logic        wb_bd,
   input  logic [6:0]  wb_ex_vec,
   input  logic        wb_eret,
   input  logic [5:0]  hw_int,
   input  logic [1:0]  sw_int,
   input  logic        cp0_status_ie,
   input  logic        cp0_status_exl,
   input  logic [7:0]  cp0_status_im,
   input  logic [31:0] cp0_epc,
   output logic        cp0_ex,
   output logic        cp0_eret,
   output logic        cp0_bd,
   output logic [4:0]  cp0_excode,
   output logic [31:0] cp0_wdata,
   output logic [7:0]  cp0_ip,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] REDIR = 2'd2;

   // Handshake: redirect_valid rises in REDIR and, with redirect_pc, stays stable until
   // the cycle redirect_valid & redirect_ready, which completes the transfer.

   logic [1:0]  state;
   logic [5:0]  sync_q [INT_SYNC];
   logic        int_pend;
   logic        trig_ex;
   logic        trig_eret;
   logic [4:0]  excode_sel;
   logic        cap_eret;
   logic        cap_bd;
   logic [4:0]  cap_excode;
   logic [31:0] cap_pc;
   logic [31:0] cap_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < INT_SYNC; i++) sync_q[i] <= 6'd0;
      end else begin
         sync_q[0] <= hw_int;
         for (int i = 1; i < INT_SYNC; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign cp0_ip   = {sync_q[INT_SYNC-1], sw_int};
   assign int_pend = cp0_status_ie & ~cp0_status_exl & (|(cp0_ip & cp0_status_im));

   assign trig_ex   = wb_valid & (int_pend | (|wb_ex_vec));
   assign trig_eret = wb_valid & wb_eret & ~trig_ex;

   // Interrupt outranks every synchronous cause of the committing instruction.
   always_comb begin
      excode_sel = 5'h00;
      if (int_pend)          excode_sel = 5'h00;
      else if (wb_ex_vec[6]) excode_sel = 5'h04;
      else if (wb_ex_vec[5]) excode_sel = 5'h0A;
      else if (wb_ex_vec[4]) excode_sel = 5'h0C;
      else if (wb_ex_vec[3]) excode_sel = 5'h08;
      else if (wb_ex_vec[2]) excode_sel = 5'h09;
      else if (wb_ex_vec[1]) excode_sel = 5'h04;
      else if (wb_ex_vec[0]) excode_sel = 5'h05;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cap_eret   <= 1'b0;
         cap_bd     <= 1'b0;
         cap_excode <= 5'd0;
         cap_pc     <= 32'd0;
         cap_target <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (trig_ex || trig_eret) begin
                  state      <= FLUSH;
                  cap_eret   <= trig_eret;
                  cap_bd     <= wb_bd;
                  cap_excode <= trig_ex ? excode_sel : 5'd0;
                  cap_pc     <= wb_pc;
                  cap_target <= trig_ex ? EX_VECTOR : cp0_epc;
               end
            end
            FLUSH:   state <= REDIR;
            REDIR:   if (redirect_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign wb_allowin     = (state == IDLE);
   assign flush          = (state == FLUSH);
   assign cp0_ex         = (state == FLUSH) & ~cap_eret;
   assign cp0_eret       = (state == FLUSH) & cap_eret;
   assign cp0_bd         = cap_bd;
   assign cp0_excode     = cap_excode;
   assign cp0_wdata      = cap_pc;
   assign redirect_valid = (state == REDIR);
   assign redirect_pc    = cap_target;
   assign dbg_state      = state;

endmodule

// File: tb/tb_cp0_ex_ctrl.sv
// Directed bench for cp0_ex_ctrl: exception/ERET sequencing, priority, interrupt
// masking and synchronisation, delay slot capture and reset during redirect.
module tb_cp0_ex_ctrl;

   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic        wb_allowin;
   logic [31:0] wb_pc;
   logic        wb_bd;
   logic [6:0]  wb_ex_vec;
   logic        wb_eret;
   logic [5:0]  hw_int;
   logic [1:0]  sw_int;
   logic        cp0_status_ie;
   logic        cp0_status_exl;
   logic [7:0]  cp0_status_im;
   logic [31:0] cp0_epc;
   logic        cp0_ex;
   logic        cp0_eret;
   logic        cp0_bd;
   logic [4:0]  cp0_excode;
   logic [31:0] cp0_wdata;
   logic [7:0]  cp0_ip;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic [1:0]  dbg_state;

   int checks;
   int errors;

   cp0_ex_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .wb_valid       (wb_valid),
      .wb_allowin     (wb_allowin),
      .wb_pc          (wb_pc),
      .wb_bd          (wb_bd),
      .wb_ex_vec      (wb_ex_vec),
      .wb_eret        (wb_eret),
      .hw_int         (hw_int),
      .sw_int         (sw_int),
      .cp0_status_ie  (cp0_status_ie),
      .cp0_status_exl (cp0_status_exl),
      .cp0_status_im  (cp0_status_im),
      .cp0_epc        (cp0_epc),
      .cp0_ex         (cp0_ex),
      .cp0_eret       (cp0_eret),
      .cp0_bd         (cp0_bd),
      .cp0_excode     (cp0_excode),
      .cp0_wdata      (cp0_wdata),
      .cp0_ip         (cp0_ip),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one active edge; inputs are driven and outputs sampled 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_wb();
      wb_valid  = 1'b0;
      wb_ex_vec = 7'd0;
      wb_eret   = 1'b0;
      wb_bd     = 1'b0;
   endtask

   task automatic present(input logic [31:0] pc, input logic [6:0] vec, input logic eret, input logic bd);
      wb_valid  = 1'b1;
      wb_pc     = pc;
      wb_ex_vec = vec;
      wb_eret   = eret;
      wb_bd     = bd;
   endtask

   // from FLUSH: enter REDIR, accept immediately, expect IDLE the cycle after
   task automatic finish_redirect(input string tag, input logic [31:0] exp_pc);
      step();
      chk({tag, "_rvalid"}, redirect_valid, 1);
      chk({tag, "_rpc"}, redirect_pc, exp_pc);
      chk({tag, "_allowin_redir"}, wb_allowin, 0);
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      chk({tag, "_idle"}, dbg_state, 0);
      chk({tag, "_rvalid_done"}, redirect_valid, 0);
      chk({tag, "_allowin_done"}, wb_allowin, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      clear_wb();
      wb_pc = 32'd0;
      hw_int = 6'd0;
      sw_int = 2'd0;
      cp0_status_ie = 1'b0;
      cp0_status_exl = 1'b0;
      cp0_status_im = 8'd0;
      cp0_epc = 32'd0;
      redirect_ready = 1'b0;
      step();
      step();

      // reset state
      chk("rst_allowin", wb_allowin, 1);
      chk("rst_ex", cp0_ex, 0);
      chk("rst_eret", cp0_eret, 0);
      chk("rst_flush", flush, 0);
      chk("rst_rvalid", redirect_valid, 0);
      chk("rst_bd", cp0_bd, 0);
      chk("rst_excode", cp0_excode, 0);
      chk("rst_wdata", cp0_wdata, 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_ip", cp0_ip, 0);
      chk("rst_state", dbg_state, 0);
      reset = 1'b0;
      step();

      // syscall with fetch stalling the redirect for 3 cycles
      present(32'h80001000, 7'b0001000, 1'b0, 1'b0);
      step();
      chk("sys_ex", cp0_ex, 1);
      chk("sys_eret", cp0_eret, 0);
      chk("sys_flush", flush, 1);
      chk("sys_excode", cp0_excode, 5'h08);
      chk("sys_wdata", cp0_wdata, 32'h80001000);
      chk("sys_bd", cp0_bd, 0);
      chk("sys_allowin", wb_allowin, 0);
      chk("sys_rvalid_t1", redirect_valid, 0);
      // a commit offered while blocked must not disturb the capture
      present(32'h80001004, 7'b0010000, 1'b0, 1'b1);
      step();
      chk("sys_rvalid_t2", redirect_valid, 1);
      chk("sys_rpc_t2", redirect_pc, 32'hBFC00380);
      chk("sys_ex_t2", cp0_ex, 0);
      chk("sys_flush_t2", flush, 0);
      chk("sys_excode_hold", cp0_excode, 5'h08);
      chk("sys_wdata_hold", cp0_wdata, 32'h80001000);
      chk("sys_bd_hold", cp0_bd, 0);
      clear_wb();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("sys_rvalid_wait", redirect_valid, 1);
         chk("sys_rpc_wait", redirect_pc, 32'hBFC00380);
         chk("sys_state_wait", dbg_state, 2);
      end
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      chk("sys_idle", dbg_state, 0);
      chk("sys_allowin_done", wb_allowin, 1);
      chk("sys_rvalid_done", redirect_valid, 0);

      // priority: RI over Ov and AdEL(load)
      present(32'h80001100, 7'b0110010, 1'b0, 1'b0);
      step();
      chk("pri_ri_ex", cp0_ex, 1);
      chk("pri_ri_excode", cp0_excode, 5'h0A);
      clear_wb();
      finish_redirect("pri_ri", 32'hBFC00380);

      // priority: interrupt over AdEL(fetch)
      cp0_status_ie = 1'b1;
      cp0_status_im = 8'hFF;
      hw_int = 6'b000001;
      step();
      step();
      chk("pri_int_ip", cp0_ip, 8'h04);
      present(32'h80001200, 7'b1000000, 1'b0, 1'b0);
      step();
      chk("pri_int_ex", cp0_ex, 1);
      chk("pri_int_excode", cp0_excode, 5'h00);
      clear_wb();
      hw_int = 6'd0;
      finish_redirect("pri_int", 32'hBFC00380);

      // ERET to EPC sampled at trigger
      cp0_epc = 32'h80002004;
      present(32'h80001300, 7'd0, 1'b1, 1'b0);
      step();
      chk("eret_pulse", cp0_eret, 1);
      chk("eret_ex", cp0_ex, 0);
      chk("eret_flush", flush, 1);
      clear_wb();
      cp0_epc = 32'h12345678;
      finish_redirect("eret", 32'h80002004);

      // ERET with breakpoint: the exception wins
      present(32'h80001400, 7'b0000100, 1'b1, 1'b0);
      step();
      chk("eretbp_ex", cp0_ex, 1);
      chk("eretbp_eret", cp0_eret, 0);
      chk("eretbp_excode", cp0_excode, 5'h09);
      clear_wb();
      finish_redirect("eretbp", 32'hBFC00380);

      // interrupt masked by IM[4]
      cp0_status_im = 8'hEF;
      hw_int = 6'b000100;
      step();
      step();
      chk("mask_ip", cp0_ip, 8'h10);
      present(32'h80001500, 7'd0, 1'b0, 1'b0);
      step();
      chk("mask_state", dbg_state, 0);
      chk("mask_flush", flush, 0);
      chk("mask_ex", cp0_ex, 0);
      clear_wb();
      step();
      cp0_status_im = 8'hFF;
      present(32'h80001504, 7'd0, 1'b0, 1'b0);
      step();
      chk("unmask_ex", cp0_ex, 1);
      chk("unmask_excode", cp0_excode, 5'h00);
      chk("unmask_wdata", cp0_wdata, 32'h80001504);
      clear_wb();
      finish_redirect("unmask", 32'hBFC00380);
      cp0_status_exl = 1'b1;
      present(32'h80001508, 7'd0, 1'b0, 1'b0);
      step();
      chk("exl_state", dbg_state, 0);
      chk("exl_flush", flush, 0);
      clear_wb();
      cp0_status_exl = 1'b0;
      hw_int = 6'd0;
      step();
      step();
      chk("pulse_ip_idle", cp0_ip, 8'h00);

      // one-cycle pulse on hw_int[2] reaches cp0_ip[4] after two edges
      hw_int = 6'b000100;
      step();
      hw_int = 6'd0;
      chk("pulse_ip_e1", cp0_ip, 8'h00);
      step();
      chk("pulse_ip_e2", cp0_ip, 8'h10);
      step();
      chk("pulse_ip_e3", cp0_ip, 8'h00);

      // delay slot overflow
      present(32'h80000104, 7'b0010000, 1'b0, 1'b1);
      step();
      chk("bd_ex", cp0_ex, 1);
      chk("bd_bd", cp0_bd, 1);
      chk("bd_wdata", cp0_wdata, 32'h80000104);
      chk("bd_excode", cp0_excode, 5'h0C);
      clear_wb();
      finish_redirect("bd", 32'hBFC00380);
      chk("bd_hold", cp0_bd, 1);

      // reset while in REDIR, then a fresh syscall
      present(32'h80002000, 7'b0001000, 1'b0, 1'b0);
      step();
      clear_wb();
      step();
      chk("rr_rvalid_before", redirect_valid, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rr_rvalid", redirect_valid, 0);
      chk("rr_allowin", wb_allowin, 1);
      chk("rr_state", dbg_state, 0);
      chk("rr_excode", cp0_excode, 0);
      chk("rr_rpc", redirect_pc, 0);
      present(32'h80003000, 7'b0001000, 1'b0, 1'b0);
      step();
      chk("rr_sys_ex", cp0_ex, 1);
      chk("rr_sys_flush", flush, 1);
      chk("rr_sys_excode", cp0_excode, 5'h08);
      chk("rr_sys_wdata", cp0_wdata, 32'h80003000);
      clear_wb();
      finish_redirect("rr_sys", 32'hBFC00380);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
